ahb_conv_sequencer: RTL and testbench
=====================================

Name: ahb_conv_sequencer

Overview:
AHB-Lite master that programs and runs the convolution accelerator's register slave on behalf of a local command port. One accepted command becomes a fixed sequence of single transfers:
- write N, K, base_in, base_k, base_out;
- write start=1;
- poll the done register until bit0=1 or a timeout;
- write start=0.

The block sits between a host-side controller/DMA and the AHB interconnect that serves the accelerator.

Parameters:
BASE_ADDR, 32'h4000_0000, AHB base address of the accelerator register window.
POLL_GAP, 4, idle HCLK cycles between consecutive done-polls (0 = back-to-back).
TIMEOUT_POLLS, 1024, maximum done-reads before a timeout is declared (≥1).

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
cmd_n  in  8  image size N
cmd_k  in  8  kernel size K
cmd_base_in  in  18  input image base word address
cmd_base_k  in  18  kernel base
cmd_base_out  in  18  output base
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
err_code  out  2  valid with done: 00 ok, 01 bus ERROR, 10 timeout
HADDR  out  32  AHB address
HTRANS  out  2  IDLE (00) or NONSEQ (10) only
HWRITE  out  1  transfer direction
HSIZE  out  3  fixed 3'b010 (word)
HBURST  out  3  fixed 3'b000 (SINGLE)
HWDATA  out  32  write data, data phase
HRDATA  in  32  read data
HREADY  in  1  bus ready
HRESP  in  1  0 OKAY, 1 ERROR

Behaviour:
- Reset values (async, HRESETn low) for all registered outputs:
  - state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0;
  - done=0, err_code=00, busy=0;
  - step=0, poll_cnt=0, gap_cnt=0.
  - Reset mid-sequence abandons the transfer immediately; no completion pulse.
- Step table (offset, dir, data):
  - 0: 0x08 W {24'0,N}
  - 1: 0x0C W {24'0,K}
  - 2: 0x10 W {14'0,base_in}
  - 3: 0x14 W {14'0,base_k}
  - 4: 0x18 W {14'0,base_out}
  - 5: 0x00 W 32'h1
  - 6: 0x04 R (poll)
  - 7: 0x00 W 32'h0
- Transfers are non-pipelined: an address phase, then a data phase with HTRANS=IDLE. A new NONSEQ is never issued during a data phase.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid: capture all cmd_* into internal registers, step=0, poll_cnt=0, go ADDR.
  - cmd_* changes after acceptance have no effect.
- ADDR:
  - HTRANS=NONSEQ, HADDR=BASE_ADDR+offset(step), HWRITE=(step≠6).
  - Hold all outputs until HREADY=1, then go DATA.
- DATA:
  - HTRANS=IDLE; HWDATA=data(step), stable for the whole data phase; wait for HREADY=1.
  - If HRESP=1 in any DATA cycle: latch err=01 and go FINISH on the cycle HREADY=1 (end of two-cycle ERROR response). No start-clear is attempted.
  - On HREADY=1 & HRESP=0:
    - step<5: step+1 → ADDR.
    - step=5: step=6 → ADDR (first poll issued immediately).
    - step=6, HRDATA[0]=1: step=7 → ADDR.
    - step=6, HRDATA[0]=0: poll_cnt+1. If poll_cnt+1==TIMEOUT_POLLS, latch err=10, step=7 → ADDR (start is still cleared). Else → GAP, or ADDR if POLL_GAP=0.
    - step=7: → FINISH.
- GAP: gap_cnt counts POLL_GAP cycles with HTRANS=IDLE, then → ADDR (step 6).
- FINISH: done=1 and err_code=latched value for exactly one cycle, then → IDLE. err_code holds until the next acceptance.
- busy=1 in every state except IDLE.
- Latency with zero wait states and done already set: acceptance at cycle 0, done pulse at cycle 17.
- Counters are sized for TIMEOUT_POLLS and POLL_GAP with no wrap; poll_cnt saturates at its terminal value.

Test Plan:
1. N=8, K=3, bases 0x100/0x200/0x300, HREADY=1 always, done read 1 on first poll:
   - 8 transfers to 0x08, 0x0C, 0x10, 0x14, 0x18, 0x00, 0x04(R), 0x00;
   - HWDATA 8, 3, 0x100, 0x200, 0x300, 1, –, 0;
   - done pulse at cycle 17, err_code=00.
2. Slave returns done=0 for 3 polls, then 1, POLL_GAP=4:
   - exactly 4 reads of 0x04, each separated by 4 IDLE cycles, then the start-clear write;
   - err_code=00.
3. HREADY low for 2 cycles in the address and data phases of step 2:
   - HADDR, HTRANS and HWDATA held stable while stalled;
   - sequence completes, done delayed by 4 cycles.
4. HRESP ERROR (two-cycle) on step 3 write:
   - no further NONSEQ issued;
   - done with err_code=01; 0x18 and 0x00 never written.
5. TIMEOUT_POLLS=4, done never set:
   - 4 reads, then write 0x00 ← 0;
   - done with err_code=10.
6. HRESETn asserted during the poll phase:
   - HTRANS=00, busy=0, cmd_ready=1 immediately; no done pulse.
   - A new command after release runs the full sequence from step 0.

Source files
------------

// File: rtl/ahb_conv_sequencer_if.sv
// Bundle of the host command port and the AHB-Lite master bus used by
// ahb_conv_sequencer. The master modport is the sequencer's view; the slave
// modport is the view of whatever sits on the other side (host + interconnect).
interface ahb_conv_sequencer_if;
  // host command side
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_n;
  logic [7:0]  cmd_k;
  logic [17:0] cmd_base_in;
  logic [17:0] cmd_base_k;
  logic [17:0] cmd_base_out;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  // AHB-Lite master side
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_n, cmd_k, cmd_base_in, cmd_base_k, cmd_base_out,
    output cmd_ready, busy, done, err_code,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_n, cmd_k, cmd_base_in, cmd_base_k, cmd_base_out,
    input  cmd_ready, busy, done, err_code,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_conv_sequencer.sv
// AHB-Lite master that programs the convolution accelerator's register window,
// starts it, polls its done register and finally clears start.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a command, cmd_ready=1
//   S_ADDR   | address phase of the transfer for the current step (NONSEQ)
//   S_DATA   | data phase of that transfer, HTRANS=IDLE, HWDATA held
//   S_GAP    | idle spacing between two done-polls
//   S_FINISH | one-cycle done pulse with err_code, then back to idle
//
// Steps: 0..4 write N, K, base_in, base_k, base_out; 5 write start=1;
// 6 poll done; 7 write start=0. Transfers are never pipelined.
module ahb_conv_sequencer #(
  parameter logic [31:0] BASE_ADDR     = 32'h4000_0000,
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_conv_sequencer_if.master bus
);

  localparam int unsigned PW = $clog2(TIMEOUT_POLLS + 1);
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(TIMEOUT_POLLS);
  localparam logic [GW-1:0] GAP_LOAD  = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;

  localparam logic [2:0] STEP_START = 3'd5;
  localparam logic [2:0] STEP_POLL  = 3'd6;
  localparam logic [2:0] STEP_CLEAR = 3'd7;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BUS     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_GAP,
    S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]  err_q, err_d;

  logic [7:0]  n_q, n_d;
  logic [7:0]  k_q, k_d;
  logic [17:0] base_in_q, base_in_d;
  logic [17:0] base_k_q, base_k_d;
  logic [17:0] base_out_q, base_out_d;

  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        done_q, done_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        busy_q, busy_d;

  logic [31:0] step_wdata;
  logic [PW-1:0] poll_inc;
  logic        accept;
  logic        unused_rdata;

  function automatic logic [7:0] step_offset(input logic [2:0] s);
    case (s)
      3'd0:    step_offset = 8'h08;
      3'd1:    step_offset = 8'h0C;
      3'd2:    step_offset = 8'h10;
      3'd3:    step_offset = 8'h14;
      3'd4:    step_offset = 8'h18;
      3'd6:    step_offset = 8'h04;
      default: step_offset = 8'h00;
    endcase
  endfunction

  assign unused_rdata = ^bus.HRDATA[31:1];
  assign poll_inc     = poll_cnt_q + PW'(1);
  assign accept       = (state_q == S_IDLE) && bus.cmd_valid;

  // Write data belonging to the current step, taken from the captured command.
  always_comb begin
    step_wdata = 32'h0;
    case (step_q)
      3'd0:    step_wdata = {24'h0, n_q};
      3'd1:    step_wdata = {24'h0, k_q};
      3'd2:    step_wdata = {14'h0, base_in_q};
      3'd3:    step_wdata = {14'h0, base_k_q};
      3'd4:    step_wdata = {14'h0, base_out_q};
      3'd5:    step_wdata = 32'h1;
      default: step_wdata = 32'h0;
    endcase
  end

  // Next-state logic for the sequencer and its step/poll/gap counters.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    err_d      = err_q;
    n_d        = n_q;
    k_d        = k_q;
    base_in_d  = base_in_q;
    base_k_d   = base_k_q;
    base_out_d = base_out_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          n_d        = bus.cmd_n;
          k_d        = bus.cmd_k;
          base_in_d  = bus.cmd_base_in;
          base_k_d   = bus.cmd_base_k;
          base_out_d = bus.cmd_base_out;
          step_d     = 3'd0;
          poll_cnt_d = '0;
          err_d      = ERR_OK;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (bus.HRESP) begin
          // ERROR response: abandon the sequence, start is deliberately left set
          err_d = ERR_BUS;
          if (bus.HREADY) state_d = S_FINISH;
        end else if (bus.HREADY) begin
          if (step_q < STEP_START) begin
            step_d  = step_q + 3'd1;
            state_d = S_ADDR;
          end else if (step_q == STEP_START) begin
            step_d  = STEP_POLL;
            state_d = S_ADDR;
          end else if (step_q == STEP_POLL) begin
            if (bus.HRDATA[0]) begin
              step_d  = STEP_CLEAR;
              state_d = S_ADDR;
            end else begin
              poll_cnt_d = poll_inc;
              if (poll_inc == POLL_LAST) begin
                // timed out, but start is still cleared
                err_d   = ERR_TIMEOUT;
                step_d  = STEP_CLEAR;
                state_d = S_ADDR;
              end else if (POLL_GAP == 0) begin
                state_d = S_ADDR;
              end else begin
                gap_cnt_d = GAP_LOAD;
                state_d   = S_GAP;
              end
            end
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_ADDR;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered bus/host outputs, derived from where the FSM goes next.
  always_comb begin
    htrans_d   = TR_IDLE;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    done_d     = (state_d == S_FINISH);
    busy_d     = (state_d != S_IDLE);
    err_code_d = err_code_q;

    if (state_d == S_ADDR) begin
      htrans_d = TR_NONSEQ;
      haddr_d  = BASE_ADDR + {24'h0, step_offset(step_d)};
      hwrite_d = (step_d != STEP_POLL);
    end
    if ((state_q == S_ADDR) && (state_d == S_DATA)) begin
      hwdata_d = step_wdata;
    end
    if (accept) err_code_d = ERR_OK;
    if (state_d == S_FINISH) err_code_d = err_d;
  end

  // State and register update; reset abandons any transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      step_q     <= 3'd0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      err_q      <= ERR_OK;
      n_q        <= 8'h0;
      k_q        <= 8'h0;
      base_in_q  <= 18'h0;
      base_k_q   <= 18'h0;
      base_out_q <= 18'h0;
      haddr_q    <= 32'h0;
      htrans_q   <= TR_IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= 32'h0;
      done_q     <= 1'b0;
      err_code_q <= ERR_OK;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      err_q      <= err_d;
      n_q        <= n_d;
      k_q        <= k_d;
      base_in_q  <= base_in_d;
      base_k_q   <= base_k_d;
      base_out_q <= base_out_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      done_q     <= done_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_code  = err_code_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HSIZE     = 3'b010;
  assign bus.HBURST    = 3'b000;
  assign bus.HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_conv_sequencer.sv
// Testbench for ahb_conv_sequencer: a reactive AHB slave, a transaction-level
// reference model of the expected transfer list, and one per-cycle checker.
module tb_ahb_conv_sequencer;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int GAP = 4;
  localparam int TMO = 4;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int   cyc = 0;

  ahb_conv_sequencer_if bus ();

  ahb_conv_sequencer #(
    .BASE_ADDR    (BASE),
    .POLL_GAP     (GAP),
    .TIMEOUT_POLLS(TMO)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  int ncmp = 0;
  int nbad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // per-command slave behaviour
  int cfg_zero_polls = 0;
  int cfg_err_idx    = -1;
  int cfg_stall_idx  = -1;
  int cfg_stall_n    = 0;
  bit cfg_rand_waits = 1'b0;

  function automatic int pick_wait(input int idx);
    if (idx == cfg_stall_idx) return cfg_stall_n;
    if (cfg_rand_waits && ($urandom_range(0, 3) == 0)) return int'($urandom_range(1, 2));
    return 0;
  endfunction

  // ---------------- reactive AHB slave ----------------
  initial begin
    bit s_dp, s_aw_set, s_err, s_is_read, last_ns, last_hwrite, last_hready;
    int s_wait, s_xfer, s_reads, s_errph;
    logic [31:0] rd;
    s_dp = 0; s_aw_set = 0; s_err = 0; s_is_read = 0;
    last_ns = 0; last_hwrite = 0; last_hready = 1;
    s_wait = 0; s_xfer = 0; s_reads = 0; s_errph = 0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
    forever begin
      @(posedge HCLK);
      if (!HRESETn) begin
        s_dp = 0; s_aw_set = 0; last_ns = 0; last_hready = 1;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        continue;
      end
      if (last_hready) begin
        if (s_dp) begin
          s_dp = 0;
          if (s_is_read) s_reads++;
          s_xfer++;
        end else if (last_ns) begin
          s_dp = 1;
          s_aw_set = 0;
          s_is_read = !last_hwrite;
          s_err = (s_xfer == cfg_err_idx);
          s_errph = 0;
          s_wait = pick_wait(s_xfer);
        end
      end
      #1;
      if (!bus.busy) begin
        s_xfer = 0;
        s_reads = 0;
      end
      if (s_dp) begin
        if (s_err) begin
          bus.HRESP  = 1'b1;
          bus.HREADY = (s_errph == 1);
          s_errph++;
        end else begin
          bus.HRESP  = 1'b0;
          bus.HREADY = (s_wait == 0);
          if (s_wait > 0) s_wait--;
        end
        rd = $urandom();
        rd[0] = (s_reads >= cfg_zero_polls);
        bus.HRDATA = rd;
      end else if (bus.HTRANS == 2'b10) begin
        if (!s_aw_set) begin
          s_aw_set = 1;
          s_wait = pick_wait(s_xfer);
        end
        bus.HRESP  = 1'b0;
        bus.HREADY = (s_wait == 0);
        if (s_wait > 0) s_wait--;
      end else begin
        bus.HRESP  = 1'b0;
        bus.HREADY = 1'b1;
      end
      last_ns     = (bus.HTRANS == 2'b10);
      last_hwrite = bus.HWRITE;
      last_hready = bus.HREADY;
    end
  end

  // ---------------- reference model + checker ----------------
  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] data;
    bit          err;
    int          gap;
  } xfer_t;

  xfer_t expq[$];
  int    n_done = 0;
  int    last_lat = 0;
  logic [1:0] last_err = 2'b00;
  int    cmd_xfers = 0;
  int    cmd_reads = 0;

  function automatic xfer_t mk(input logic [31:0] a, input bit w, input logic [31:0] d, input int g);
    xfer_t x;
    x.addr = a; x.wr = w; x.data = d; x.err = 1'b0; x.gap = g;
    return x;
  endfunction

  initial begin
    bit m_active, dp, dp_first, a_hold, dp_wr, a_wr;
    int acc_cyc, done_due, idle_cnt, idle_exp, nreads;
    logic [1:0] m_err;
    logic [31:0] dp_addr, dp_wdata, a_addr;
    xfer_t x;
    m_active = 0; dp = 0; dp_first = 0; a_hold = 0; dp_wr = 0; a_wr = 0;
    acc_cyc = -100; done_due = -1; idle_cnt = 0; idle_exp = 0; nreads = 0;
    m_err = 2'b00; dp_addr = 0; dp_wdata = 0; a_addr = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        expq.delete();
        m_active = 0; dp = 0; a_hold = 0; done_due = -1; last_err = 2'b00;
        continue;
      end
      if (cyc == acc_cyc + 1) m_active = 1;
      check("hsize", 32'(bus.HSIZE), 32'h2);
      check("hburst", 32'(bus.HBURST), 32'h0);
      check("htrans_legal", 32'(bus.HTRANS == 2'b00 || bus.HTRANS == 2'b10), 32'h1);
      check("cmd_ready_vs_busy", 32'(bus.cmd_ready), 32'(!bus.busy));
      check("busy", 32'(bus.busy), 32'(m_active));
      check("done", 32'(bus.done), 32'(cyc == done_due));
      if (cyc == done_due) begin
        check("err_code", 32'(bus.err_code), 32'(m_err));
        last_err = m_err;
        last_lat = cyc - acc_cyc;
        n_done++;
        m_active = 0;
        done_due = -1;
      end else if (!bus.busy) begin
        check("err_code_hold", 32'(bus.err_code), 32'(last_err));
      end

      if (a_hold) check("htrans_stall", 32'(bus.HTRANS), 32'h2);
      if (dp) begin
        check("htrans_data_phase", 32'(bus.HTRANS), 32'h0);
        if (dp_first) begin
          dp_wdata = bus.HWDATA;
          dp_first = 0;
        end else begin
          check("hwdata_stable", bus.HWDATA, dp_wdata);
        end
        if (bus.HREADY) begin
          dp = 0;
          check("xfer_expected", 32'(expq.size() != 0), 32'h1);
          if (expq.size() != 0) begin
            x = expq.pop_front();
            cmd_xfers++;
            if (!dp_wr) cmd_reads++;
            check("haddr", dp_addr, x.addr);
            check("hwrite", 32'(dp_wr), 32'(x.wr));
            if (x.wr) check("hwdata", bus.HWDATA, x.data);
            check("hresp", 32'(bus.HRESP), 32'(x.err));
            if (expq.size() == 0) done_due = cyc + 1;
            else begin
              idle_exp = x.gap;
              idle_cnt = 0;
            end
          end
        end
      end else if (bus.HTRANS == 2'b10) begin
        if (a_hold) begin
          check("haddr_stall", bus.HADDR, a_addr);
          check("hwrite_stall", 32'(bus.HWRITE), 32'(a_wr));
        end else begin
          check("nonseq_expected", 32'(expq.size() != 0), 32'h1);
          check("idle_gap", 32'(idle_cnt), 32'(idle_exp));
        end
        if (bus.HREADY) begin
          dp = 1; dp_first = 1; a_hold = 0;
          dp_addr = bus.HADDR;
          dp_wr = bus.HWRITE;
        end else begin
          a_hold = 1;
          a_addr = bus.HADDR;
          a_wr = bus.HWRITE;
        end
      end else begin
        a_hold = 0;
        if (m_active && expq.size() != 0) idle_cnt++;
      end

      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_cyc = cyc;
        cmd_xfers = 0;
        cmd_reads = 0;
        idle_cnt = 0;
        idle_exp = 0;
        expq.delete();
        expq.push_back(mk(BASE + 32'h08, 1, {24'h0, bus.cmd_n}, 0));
        expq.push_back(mk(BASE + 32'h0C, 1, {24'h0, bus.cmd_k}, 0));
        expq.push_back(mk(BASE + 32'h10, 1, {14'h0, bus.cmd_base_in}, 0));
        expq.push_back(mk(BASE + 32'h14, 1, {14'h0, bus.cmd_base_k}, 0));
        expq.push_back(mk(BASE + 32'h18, 1, {14'h0, bus.cmd_base_out}, 0));
        expq.push_back(mk(BASE + 32'h00, 1, 32'h1, 0));
        nreads = (cfg_zero_polls >= TMO) ? TMO : cfg_zero_polls + 1;
        for (int r = 0; r < nreads; r++)
          expq.push_back(mk(BASE + 32'h04, 0, 32'h0, (r < nreads - 1) ? GAP : 0));
        expq.push_back(mk(BASE + 32'h00, 1, 32'h0, 0));
        m_err = (cfg_zero_polls >= TMO) ? 2'b10 : 2'b00;
        if (cfg_err_idx >= 0 && cfg_err_idx < expq.size()) begin
          while (expq.size() > cfg_err_idx + 1) void'(expq.pop_back());
          x = expq.pop_back();
          x.err = 1'b1;
          expq.push_back(x);
          m_err = 2'b01;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_cmd(input logic [7:0] n, input logic [7:0] k, input logic [17:0] bi,
                         input logic [17:0] bk, input logic [17:0] bo, input int zp,
                         input int ei, input int si, input int sn, input bit rw,
                         input bit wait_done);
    int t;
    int base;
    @(posedge HCLK);
    #2;
    cfg_zero_polls = zp;
    cfg_err_idx = ei;
    cfg_stall_idx = si;
    cfg_stall_n = sn;
    cfg_rand_waits = rw;
    bus.cmd_n = n;
    bus.cmd_k = k;
    bus.cmd_base_in = bi;
    bus.cmd_base_k = bk;
    bus.cmd_base_out = bo;
    bus.cmd_valid = 1'b1;
    base = n_done;
    t = 0;
    @(negedge HCLK);
    while (!bus.cmd_ready && t < 100) begin
      @(negedge HCLK);
      t++;
    end
    check("cmd_accepted", 32'(bus.cmd_ready), 32'h1);
    @(posedge HCLK);
    #2;
    bus.cmd_valid = 1'b0;
    bus.cmd_n = 8'($urandom());
    bus.cmd_k = 8'($urandom());
    bus.cmd_base_in = 18'($urandom());
    bus.cmd_base_k = 18'($urandom());
    bus.cmd_base_out = 18'($urandom());
    if (wait_done) begin
      t = 0;
      while (n_done == base && t < 500) begin
        @(negedge HCLK);
        t++;
      end
      check("done_seen", 32'(n_done != base), 32'h1);
    end
  endtask

  initial begin
    int base;
    bus.cmd_valid = 1'b0;
    bus.cmd_n = 8'h0;
    bus.cmd_k = 8'h0;
    bus.cmd_base_in = 18'h0;
    bus.cmd_base_k = 18'h0;
    bus.cmd_base_out = 18'h0;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_htrans", 32'(bus.HTRANS), 32'h0);
    check("rst_haddr", bus.HADDR, 32'h0);
    check("rst_hwrite", 32'(bus.HWRITE), 32'h0);
    check("rst_hwdata", bus.HWDATA, 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err_code", 32'(bus.err_code), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;

    // basic sequence, zero wait states, done on first poll
    run_cmd(8'd8, 8'd3, 18'h100, 18'h200, 18'h300, 0, -1, -1, 0, 1'b0, 1'b1);
    check("t1_latency", 32'(last_lat), 32'd17);
    check("t1_err", 32'(last_err), 32'h0);
    check("t1_xfers", 32'(cmd_xfers), 32'd8);

    // three not-done polls, then done
    run_cmd(8'd16, 8'd5, 18'h1000, 18'h2000, 18'h3000, 3, -1, -1, 0, 1'b0, 1'b1);
    check("t2_latency", 32'(last_lat), 32'd35);
    check("t2_reads", 32'(cmd_reads), 32'd4);
    check("t2_err", 32'(last_err), 32'h0);

    // two-cycle stalls in both phases of step 2
    run_cmd(8'd8, 8'd3, 18'h100, 18'h200, 18'h300, 0, -1, 2, 2, 1'b0, 1'b1);
    check("t3_latency", 32'(last_lat), 32'd21);
    check("t3_err", 32'(last_err), 32'h0);

    // ERROR response on step 3
    run_cmd(8'd8, 8'd3, 18'h100, 18'h200, 18'h300, 0, 3, -1, 0, 1'b0, 1'b1);
    check("t4_latency", 32'(last_lat), 32'd10);
    check("t4_err", 32'(last_err), 32'h1);
    check("t4_xfers", 32'(cmd_xfers), 32'd4);

    // done never set: timeout after TMO polls, start still cleared
    run_cmd(8'd9, 8'd7, 18'h3FFFF, 18'h0, 18'h15555, 100, -1, -1, 0, 1'b0, 1'b1);
    check("t5_latency", 32'(last_lat), 32'd35);
    check("t5_reads", 32'(cmd_reads), 32'd4);
    check("t5_err", 32'(last_err), 32'h2);

    // reset in the middle of polling
    base = n_done;
    run_cmd(8'd4, 8'd2, 18'h10, 18'h20, 18'h30, 100, -1, -1, 0, 1'b0, 1'b0);
    repeat (13) @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    #1;
    check("t6_htrans", 32'(bus.HTRANS), 32'h0);
    check("t6_busy", 32'(bus.busy), 32'h0);
    check("t6_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    repeat (2) @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    repeat (3) @(posedge HCLK);
    check("t6_no_done", 32'(n_done), 32'(base));
    run_cmd(8'd8, 8'd3, 18'h100, 18'h200, 18'h300, 0, -1, -1, 0, 1'b0, 1'b1);
    check("t6_latency", 32'(last_lat), 32'd17);
    check("t6_xfers", 32'(cmd_xfers), 32'd8);

    // randomized commands, slave wait states, poll counts and errors
    for (int i = 0; i < 25; i++) begin
      run_cmd(8'($urandom()), 8'($urandom()), 18'($urandom()), 18'($urandom()),
              18'($urandom()), int'($urandom_range(0, 5)),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1,
              -1, 0, 1'b1, 1'b1);
    end

    repeat (5) @(posedge HCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
